// File: rtl/full_adder_bist.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_bist
//  Description : Built-in self-test checker for a 1-bit full adder. Drives all
//                eight {A,B,Y} vectors into the adder under test, waits
//                SETTLE_CYCLES cycles per vector, then compares the adder's
//                carry/sum against majority/xor and reports pass/fail status.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                start             - level; launches a run from IDLE or DONE
//                dut_c, dut_s      - carry/sum returned by the adder
//                A, B, Y           - registered operand/carry-in drive
//                busy, done        - run in progress / run finished
//                pass, fail        - DONE-qualified verdict
//                err_count         - mismatching vectors in current/last run
//                first_fail        - {A,B,Y} of the first mismatching vector
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_bist #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_c,
    input  logic       dut_s,
    output logic       A,
    output logic       B,
    output logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fail,
    output logic [3:0] err_count,
    output logic [2:0] first_fail
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] vec_q,   vec_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [3:0] err_q,   err_d;
    logic [2:0] ff_q,    ff_d;
    logic [2:0] aby_q,   aby_d;

    logic       exp_c;
    logic       exp_s;
    logic       mismatch;

    // In SAMPLE the operand register still holds vec, so the reference is
    // computed from what the adder is actually seeing.
    assign exp_c    = (aby_q[2] & aby_q[1]) | (aby_q[2] & aby_q[0]) | (aby_q[1] & aby_q[0]);
    assign exp_s    = aby_q[2] ^ aby_q[1] ^ aby_q[0];
    assign mismatch = (dut_c != exp_c) || (dut_s != exp_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= 3'd0;
            cnt_q   <= 4'd0;
            err_q   <= 4'd0;
            ff_q    <= 3'd0;
            aby_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            aby_q   <= aby_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ff_d    = ff_q;
        aby_d   = aby_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_d   = 4'd0;
                    ff_d    = 3'd0;
                    vec_d   = 3'd0;
                    cnt_d   = 4'd0;
                    aby_d   = 3'd0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                aby_d = vec_q;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 4'd1;
                    // err_q is still zero only for the first mismatch of the run
                    if (err_q == 4'd0) begin
                        ff_d = vec_q;
                    end
                end
                if (vec_q == 3'd7) begin
                    aby_d   = 3'd0;
                    state_d = ST_DONE;
                end else begin
                    // Next vector is launched on the same edge that re-enters
                    // DRIVE, giving the adder the full settle window.
                    vec_d   = vec_q + 3'd1;
                    aby_d   = vec_q + 3'd1;
                    cnt_d   = 4'd0;
                    state_d = ST_DRIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign A          = aby_q[2];
    assign B          = aby_q[1];
    assign Y          = aby_q[0];
    assign busy       = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done       = (state_q == ST_DONE);
    assign pass       = done && (err_q == 4'd0);
    assign fail       = done && (err_q != 4'd0);
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule
`default_nettype wire

// File: tb/tb_full_adder_bist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_full_adder_bist
//  Description : Self-checking bench for full_adder_bist. Two checker
//                instances (SETTLE_CYCLES=4 and 1) each drive a behavioural
//                adder with selectable faults; expected run results are
//                queued at start and compared when done rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_full_adder_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start4, start1;
    int         mode4, mode1;
    int         sel;

    logic       a4, b4, y4, c4, s4, busy4, done4, pass4, fail4;
    logic [3:0] err4;
    logic [2:0] ff4;
    logic       a1, b1, y1, c1, s1, busy1, done1, pass1, fail1;
    logic [3:0] err1;
    logic [2:0] ff1;

    // Behavioural adder: {carry,sum} from arithmetic, then an optional fault.
    // mode 0 correct, 1 sum stuck at 0, 2 carry inverted, 3 sum wrong on 110.
    function automatic logic [1:0] adder_model(input logic [2:0] v, input int mode);
        logic [1:0] cs;
        cs = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
        case (mode)
            1: cs[0] = 1'b0;
            2: cs[1] = ~cs[1];
            3: if (v == 3'b110) cs[0] = ~cs[0];
            default: ;
        endcase
        return cs;
    endfunction

    assign {c4, s4} = adder_model({a4, b4, y4}, mode4);
    assign {c1, s1} = adder_model({a1, b1, y1}, mode1);

    full_adder_bist #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .dut_c(c4), .dut_s(s4),
        .A(a4), .B(b4), .Y(y4), .busy(busy4), .done(done4), .pass(pass4),
        .fail(fail4), .err_count(err4), .first_fail(ff4)
    );

    full_adder_bist #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .dut_c(c1), .dut_s(s1),
        .A(a1), .B(b1), .Y(y1), .busy(busy1), .done(done1), .pass(pass1),
        .fail(fail1), .err_count(err1), .first_fail(ff1)
    );

    // Observation of whichever instance is under test
    logic [2:0] w_aby, w_ff;
    logic [3:0] w_err;
    logic       w_busy, w_done, w_pass, w_fail;
    assign w_aby  = (sel == 1) ? {a1, b1, y1} : {a4, b4, y4};
    assign w_ff   = (sel == 1) ? ff1   : ff4;
    assign w_err  = (sel == 1) ? err1  : err4;
    assign w_busy = (sel == 1) ? busy1 : busy4;
    assign w_done = (sel == 1) ? done1 : done4;
    assign w_pass = (sel == 1) ? pass1 : pass4;
    assign w_fail = (sel == 1) ? fail1 : fail4;

    typedef struct {
        int         cyc;
        logic [3:0] err;
        logic [2:0] ff;
        logic       pass;
    } exp_t;
    exp_t exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic set_start(input logic v);
        if (sel == 1) start1 = v;
        else          start4 = v;
    endtask

    task automatic set_mode(input int m);
        if (sel == 1) mode1 = m;
        else          mode4 = m;
    endtask

    // Reference result of a full run for a given fault mode and settle time
    task automatic push_expected(input int mode, input int s);
        exp_t e;
        e.err  = 4'd0;
        e.ff   = 3'd0;
        for (int v = 0; v < 8; v++) begin
            if (adder_model(3'(v), mode) != adder_model(3'(v), 0)) begin
                if (e.err == 4'd0) e.ff = 3'(v);
                e.err = e.err + 4'd1;
            end
        end
        e.pass = (e.err == 4'd0);
        e.cyc  = 8 * (s + 1) + 1;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_aby"},  32'(w_aby),  0);
        check({tag, "_busy"}, 32'(w_busy), 0);
        check({tag, "_done"}, 32'(w_done), 0);
        check({tag, "_pass"}, 32'(w_pass), 0);
        check({tag, "_fail"}, 32'(w_fail), 0);
        check({tag, "_err"},  32'(w_err),  0);
        check({tag, "_ff"},   32'(w_ff),   0);
    endtask

    // Launch a run (start pulsed or held), follow the vector sequence, and
    // compare the queued expectation when done appears.
    task automatic do_run(input int mode, input bit hold);
        int   s, c;
        bit   seen;
        exp_t e;
        s = (sel == 1) ? 1 : 4;
        set_mode(mode);
        push_expected(mode, s);
        @(negedge clk);
        set_start(1'b1);
        seen = 0;
        c = 0;
        for (int k = 1; k <= 8 * (s + 1) + 10; k++) begin
            @(negedge clk);
            c = k;
            if (k == 1 && !hold) set_start(1'b0);
            if (w_done) begin
                seen = 1;
                break;
            end
            if (k == 1) check("busy_at_1", 32'(w_busy), 1);
            if (k <= 8 * (s + 1)) check("vec", 32'(w_aby), 32'((k - 1) / (s + 1)));
        end
        if (!seen) check("done_timeout", 0, 1);
        e = exp_q.pop_front();
        check("done_cycle", 32'(c),      32'(e.cyc));
        check("err_count",  32'(w_err),  32'(e.err));
        check("first_fail", 32'(w_ff),   32'(e.ff));
        check("pass",       32'(w_pass), 32'(e.pass));
        check("fail",       32'(w_fail), 32'(!e.pass));
        check("busy_done",  32'(w_busy), 0);
        check("aby_done",   32'(w_aby),  0);
    endtask

    initial begin
        rst = 1'b1; start4 = 1'b0; start1 = 1'b0;
        mode4 = 0; mode1 = 0; sel = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset("rst4");
        sel = 1;
        chk_reset("rst1");

        // S=4: correct, sum stuck 0, carry inverted (each restarted from DONE)
        sel = 0;
        do_run(0, 0);
        do_run(1, 0);
        do_run(2, 0);

        // Reset during vector 3 (cycle 17 is inside its DRIVE window)
        set_mode(0);
        @(negedge clk);
        set_start(1'b1);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 1) set_start(1'b0);
        end
        check("vec_before_rst", 32'(w_aby), 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("midrst");
        do_run(0, 0);

        // start held high: uninterrupted run, then immediate restart
        do_run(0, 1);
        @(negedge clk);
        check("hold_busy", 32'(w_busy), 1);
        check("hold_done", 32'(w_done), 0);
        check("hold_err",  32'(w_err),  0);
        set_start(1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // S=1: correct, then single fault on 110
        sel = 1;
        do_run(0, 0);
        do_run(3, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/full_adder_bist.md
# full_adder_bist

Hardware self-test checker for the 1-bit full adder (inputs A, B, carry-in Y; outputs carry C, sum S). The block is the response end of the adder's verification path: it drives all eight input vectors into a full-adder instance, samples C and S after a settle interval, compares them with the expected values, and reports the result on board-level status outputs. It sits beside the adder in the top level, for example wired to LEDs and buttons.

## Interface
- SETTLE_CYCLES, 4, cycles each vector is held before sampling; legal range 1..15.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level; sampled only in IDLE or DONE to launch a run.
- dut_c  input  1  carry output of the adder under test.
- dut_s  input  1  sum output of the adder under test.
- A  output  1  adder operand A (registered).
- B  output  1  adder operand B (registered).
- Y  output  1  adder carry-in (registered).
- busy  output  1  high while a run is in progress.
- done  output  1  high in DONE.
- pass  output  1  high in DONE when no mismatches were recorded.
- fail  output  1  high in DONE when one or more mismatches were recorded.
- err_count  output  4  mismatch count for the current or last run, 0..8.
- first_fail  output  3  vector {A,B,Y} of the first mismatch; 0 if none.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- Reset values: state=IDLE, A=B=Y=0, busy=done=pass=fail=0, err_count=0, first_fail=0, vec=0, settle counter=0.
- IDLE, start=1: clear err_count, first_fail, vec and the settle counter, then go to DRIVE.
- Vector bit order: A=vec[2], B=vec[1], Y=vec[0]; vec steps 0 through 7.
- DRIVE: {A,B,Y}=vec; the settle counter counts 0..SETTLE_CYCLES-1; at the terminal count the state goes to SAMPLE.
- SAMPLE: {A,B,Y} stays at vec.
  - Expected C = majority(A,B,Y); expected S = A^B^Y.
  - A mismatch on either output counts once per vector: err_count increments.
  - If this is the first mismatch of the run, first_fail=vec.
  - If vec=7, go to DONE; otherwise vec increments, the counter clears, and the state returns to DRIVE.
- DONE:
  - A=B=Y=0, done=1.
  - pass = (err_count==0); fail = ~pass.
  - Results hold until rst.
  - start=1 in DONE behaves the same as start=1 in IDLE: results clear and a new run begins.
- busy=1 exactly in DRIVE and SAMPLE. While busy, start is ignored, including when it is held high.
- err_count never exceeds 8, because there is at most one increment per vector.
- dut_c and dut_s are used only in SAMPLE; they are ignored in every other state.

## Timing
- Define start sampled high in IDLE as edge 0.
- Vector k is in DRIVE for cycles 1+(S+1)k through S+(S+1)k, and in SAMPLE at cycle (S+1)(k+1), where S=SETTLE_CYCLES.
- The last SAMPLE is at cycle 8(S+1). done, pass and fail are first high in cycle 8(S+1)+1.
- Total run length with the default S=4: done is high in cycle 41.
- A, B and Y change on the edge that enters DRIVE for each vector. The adder therefore has S full cycles to settle before the compare.
- err_count and first_fail update on the edge that leaves SAMPLE; they are visible in the next cycle.
- rst takes priority over all other inputs in every state. rst mid-run forces the reset values on the next edge; there is no partial result and no done pulse.
- Restart from DONE: done, pass and fail drop on the edge that enters DRIVE.

## Test plan
- Correct adder model, S=4, start pulsed one cycle -> {A,B,Y} steps through 000..111 every 5 cycles. Required at cycle 41: done=1, pass=1, fail=0, err_count=0, first_fail=000.
- Adder with sum stuck at 0 -> err_count=4 (vectors 001, 010, 100, 111), first_fail=001, fail=1, pass=0.
- Adder with carry inverted -> err_count=8, first_fail=000, fail=1.
- Assert rst for one cycle during vector 3 -> all outputs at reset values on the next cycle. A following start run with a correct adder -> pass=1 at 41 cycles after start.
- start held high throughout -> the run is uninterrupted and done=1 for one cycle at cycle 41. Because start is still high in DONE, a new run starts: busy=1 and err_count=0 on the following cycle.
- S=1 with a correct adder -> done=1 at cycle 17, pass=1. Change the adder to a fault on 110 only -> err_count=1, first_fail=110.
